// File: rtl/lift_mod3_seq_pkg.sv
// Shared types and constants for the Lift-stage mod-3 sequencer.
package lift_pkg;

  localparam int N_HRSS = 701;
  localparam int COEF_W = 13;
  localparam logic [COEF_W-1:0] MINUS_ONE = 13'd8191;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/lift_mod3_seq_mod3.sv
// Mod-3 reduction datapath: maps an unsigned coefficient to 0, 1 or -1 (mod 2^13).
module mod3
  import lift_pkg::*;
#(
  parameter int NUM_WIDTH_LENGTH = 14
) (
  input  logic [NUM_WIDTH_LENGTH-1:0] num,
  output logic [COEF_W-1:0]           result
);

  logic [1:0] rem;

  // Horner scan from MSB to LSB: rem <- (2*rem + bit) mod 3.
  always_comb begin
    rem = 2'd0;
    for (int i = NUM_WIDTH_LENGTH - 1; i >= 0; i--) begin
      case ({rem, num[i]})
        3'b000:  rem = 2'd0;
        3'b001:  rem = 2'd1;
        3'b010:  rem = 2'd2;
        3'b011:  rem = 2'd0;
        3'b100:  rem = 2'd1;
        3'b101:  rem = 2'd2;
        default: rem = 2'd0;
      endcase
    end
  end

  always_comb begin
    case (rem)
      2'd0:    result = '0;
      2'd1:    result = COEF_W'(1);
      default: result = MINUS_ONE;
    endcase
  end

endmodule

// File: rtl/lift_mod3_seq.sv
// Streams an N-coefficient polynomial from RAM through the mod-3 datapath and
// writes the reduced coefficients back (read issue, data/valid align, write).
module lift_mod3_seq
  import lift_pkg::*;
#(
  parameter int N      = N_HRSS,
  parameter int IN_W   = 14,
  parameter int OUT_W  = COEF_W,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [IN_W-1:0]   rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [OUT_W-1:0]  wr_data
);

  localparam int K_W = $clog2(N + 1);
  localparam logic [K_W-1:0] K_END = K_W'(N);

  state_t state;

  logic [K_W-1:0]    k;
  logic [K_W-1:0]    rd_k;
  logic [K_W-1:0]    s1_k;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic              rd_q;
  logic              wr_q;
  logic              s1_valid;
  logic [COEF_W-1:0] red;

  mod3 #(
    .NUM_WIDTH_LENGTH(IN_W)
  ) u_mod3 (
    .num   (rd_data),
    .result(red)
  );

  // Strobes are masked during an arbiter stall; the registers behind them freeze.
  assign rd_en = rd_q & ~hold;
  assign wr_en = wr_q & ~hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      rd_k    <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_q    <= 1'b0;
      rd_addr <= '0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            src_q   <= src_base;
            dst_q   <= dst_base;
            rd_q    <= 1'b1;
            rd_addr <= src_base;
            rd_k    <= '0;
            k       <= K_W'(1);
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          // k is the next index to issue; it reaches N once the last read is out.
          if (k == K_END) begin
            rd_q  <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= src_q + ADDR_W'(k);
            rd_k    <= k;
            k       <= k + 1'b1;
          end
        end
        DRAIN: begin
          if (!s1_valid) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // rd_data arrives one unstalled cycle after its read, alongside s1_valid/s1_k.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_k     <= '0;
      wr_q     <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (!hold) begin
      s1_valid <= rd_q;
      s1_k     <= rd_k;
      wr_q     <= s1_valid;
      if (s1_valid) begin
        wr_addr <= dst_q + ADDR_W'(s1_k);
        wr_data <= OUT_W'(red);
      end
    end
  end

endmodule

// File: tb/tb_lift_mod3_seq.sv
// Directed bench for lift_mod3_seq: RAM model, write scoreboard, timing checks.
module tb_lift_mod3_seq;

  localparam int N = 701;

  logic        clk;
  logic        rst;
  logic        start;
  logic [9:0]  src_base;
  logic [9:0]  dst_base;
  logic        hold;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [9:0]  rd_addr;
  logic [13:0] rd_data;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [12:0] wr_data;
  logic        load;

  logic [13:0] init_mem [1024];
  logic [13:0] mem      [1024];

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sb [$];

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int busyCycles;

  lift_mod3_seq dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_base(src_base),
    .dst_base(dst_base),
    .hold    (hold),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous RAM: registered read, rd_data stable when no read is strobed.
  always @(posedge clk) begin
    if (load) begin
      mem <= init_mem;
    end else begin
      if (rd_en) rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= 14'(wr_data);
    end
  end

  function automatic int redModel(input int v);
    case (v % 3)
      0:       return 0;
      1:       return 1;
      default: return 8191;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Every committed write is popped from the scoreboard and compared.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (wr_en === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_write", 1, 0);
      end else begin
        e = sb.pop_front();
        checkOutput("wr_addr", int'(wr_addr), e.addr);
        checkOutput("wr_data", int'(wr_data), e.data);
      end
    end
  end

  task automatic loadMem();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Pushes the expected write stream, then pulses start so it is taken at edge 0.
  task automatic applyStimulus(input int src, input int dst);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.addr = (dst + k) % 1024;
      e.data = redModel(int'(init_mem[(src + k) % 1024]));
      sb.push_back(e);
    end
    @(negedge clk);
    src_base = 10'(src);
    dst_base = 10'(dst);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // mode 0: plain run, 1: holds, 2: ignored starts, 3: reset at cycle 300
  task automatic runCycles(input int mode, input int src, output int latency, output int busyN);
    latency = -1;
    busyN   = 0;
    for (int n = 1; n <= 1500; n++) begin
      @(negedge clk);
      case (mode)
        1: hold = ((n >= 101 && n <= 105) || (n >= 401 && n <= 404) || n == 711);
        2: begin
          if (n == 50) begin
            start = 1'b1; src_base = 10'd500; dst_base = 10'd300;
          end else if (n == 51) begin
            start = 1'b0;
          end else if (n == N + 1) begin
            start = 1'b1; src_base = 10'd200; dst_base = 10'd200;
          end
        end
        3: if (n == 300) rst = 1'b1;
        default: ;
      endcase
      #1;
      if (n == 1) begin
        checkOutput("rd_en_first", int'(rd_en), 1);
        checkOutput("rd_addr_first", int'(rd_addr), src % 1024);
      end
      if (mode != 1 && n == N) checkOutput("rd_addr_last", int'(rd_addr), (src + N - 1) % 1024);
      if (mode != 1 && n == N + 1) checkOutput("rd_en_drain", int'(rd_en), 0);
      if (mode == 3 && n == 301) begin
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_rd_en", int'(rd_en), 0);
        checkOutput("rst_wr_en", int'(wr_en), 0);
        checkOutput("rst_rd_addr", int'(rd_addr), 0);
        checkOutput("rst_wr_addr", int'(wr_addr), 0);
        checkOutput("rst_wr_data", int'(wr_data), 0);
        rst = 1'b0;
        latency = n;
        break;
      end
      if (busy) busyN++;
      if (done) begin
        latency = n;
        break;
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; hold = 1'b0; load = 1'b0;
    src_base = '0; dst_base = '0;
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'(i);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rd_en", int'(rd_en), 0);
    checkOutput("reset_wr_en", int'(wr_en), 0);
    checkOutput("reset_rd_addr", int'(rd_addr), 0);
    checkOutput("reset_wr_addr", int'(wr_addr), 0);
    checkOutput("reset_wr_data", int'(wr_data), 0);
    rst = 1'b0;

    $display("[TB] in-place run, RAM[k]=k");
    loadMem();
    applyStimulus(0, 0);
    runCycles(0, 0, lat, busyCycles);
    checkOutput("latency_basic", lat, 704);
    checkOutput("busy_cycles_basic", busyCycles, 703);
    checkOutput("sb_empty_basic", sb.size(), 0);

    $display("[TB] run with 10 hold cycles");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    loadMem();
    applyStimulus(0, 0);
    runCycles(1, 0, lat, busyCycles);
    checkOutput("latency_hold", lat, 714);
    checkOutput("busy_cycles_hold", busyCycles, 713);
    checkOutput("sb_empty_hold", sb.size(), 0);

    $display("[TB] starts during run and DONE are ignored");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    loadMem();
    applyStimulus(37, 37);
    runCycles(2, 37, lat, busyCycles);
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("latency_ignore", lat, 704);
    checkOutput("busy_cycles_ignore", busyCycles, 703);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("no_restart_busy", int'(busy), 0);
    checkOutput("sb_empty_ignore", sb.size(), 0);

    $display("[TB] corner coefficient values, new bases");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    init_mem[0] = 14'd16383;
    init_mem[1] = 14'd5;
    init_mem[2] = 14'd7;
    init_mem[3] = 14'd8192;
    init_mem[4] = 14'd0;
    loadMem();
    applyStimulus(0, 0);
    runCycles(0, 0, lat, busyCycles);
    checkOutput("latency_corner", lat, 704);
    @(negedge clk);
    checkOutput("corner_16383", int'(mem[0]), 0);
    checkOutput("corner_5", int'(mem[1]), 8191);
    checkOutput("corner_7", int'(mem[2]), 1);
    checkOutput("corner_8192", int'(mem[3]), 8191);
    checkOutput("corner_0", int'(mem[4]), 0);

    $display("[TB] reset in mid-run");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    loadMem();
    applyStimulus(0, 0);
    runCycles(3, 0, lat, busyCycles);
    checkOutput("sb_remaining_after_rst", sb.size(), N - 298);
    sb.delete();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("idle_after_rst_wr_en", int'(wr_en), 0);

    $display("[TB] full run after reset");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    loadMem();
    applyStimulus(0, 0);
    runCycles(0, 0, lat, busyCycles);
    checkOutput("latency_after_rst", lat, 704);
    checkOutput("sb_empty_after_rst", sb.size(), 0);

    $display("[TB] out-of-place run with destination wrap");
    for (int i = 0; i < 1024; i++) init_mem[i] = 14'($urandom_range(0, 16383));
    loadMem();
    applyStimulus(0, 1020);
    runCycles(0, 0, lat, busyCycles);
    checkOutput("latency_wrap", lat, 704);
    checkOutput("sb_empty_wrap", sb.size(), 0);
    @(negedge clk);
    checkOutput("wrap_1020", int'(mem[1020]), redModel(int'(init_mem[0])));
    checkOutput("wrap_0", int'(mem[0]), redModel(int'(init_mem[4])));
    checkOutput("wrap_696", int'(mem[696]), redModel(int'(init_mem[700])));
    checkOutput("src_697_kept", int'(mem[697]), int'(init_mem[697]));
    checkOutput("src_1019_kept", int'(mem[1019]), int'(init_mem[1019]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
